dcache_line_mem: RTL

Line-granular memory responder on the far side of the data cache's refill/writeback path. Accepts one 256-bit line request at a time from the cache controller: a read (line fill) or a write (dirty-line writeback). Serialises each line into eight 32-bit accesses to an internal word memory, after a programmable access latency. Returns a full line, or a write acknowledge, over a valid/ready response channel.

---
 rtl/dcache_pkg.sv | 35 +++
 rtl/dcache_line_mem_if.sv | 25 ++
 rtl/dcache_word_ram.sv | 24 ++
 rtl/dcache_line_mem.sv | 121 ++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared constants, state encoding and line/word slicing helpers for the
// data-cache line memory responder.
package dcache_pkg;

    localparam int LINE_BITS   = 256;
    localparam int WORD_BITS   = 32;
    localparam int BEATS       = 8;
    localparam int OFFSET_BITS = 5;
    localparam int BEAT_BITS   = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_BEAT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Beat k maps to line bits [32k+31:32k], matching the cache's addr_in_block.
    function automatic logic [WORD_BITS-1:0] line_word(
        input logic [LINE_BITS-1:0] line,
        input logic [BEAT_BITS-1:0] k
    );
        return line[{k, 5'b00000} +: WORD_BITS];
    endfunction

    function automatic logic [LINE_BITS-1:0] line_put(
        input logic [LINE_BITS-1:0] line,
        input logic [BEAT_BITS-1:0] k,
        input logic [WORD_BITS-1:0] w
    );
        logic [LINE_BITS-1:0] r;
        r = line;
        r[{k, 5'b00000} +: WORD_BITS] = w;
        return r;
    endfunction

endpackage

// File: rtl/dcache_line_mem_if.sv
// Request/response channel between the cache controller (master) and the
// line memory responder (slave).
interface dcache_line_mem_if;
    import dcache_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [31:0]          req_addr;
    logic [LINE_BITS-1:0] req_line;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [LINE_BITS-1:0] resp_line;

    modport master (
        output req_valid, req_write, req_addr, req_line, resp_ready,
        input  req_ready, resp_valid, resp_line
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_line, resp_ready,
        output req_ready, resp_valid, resp_line
    );

endinterface

// File: rtl/dcache_word_ram.sv
// Single-port 32-bit word memory: combinational read, posedge write.
module dcache_word_ram #(
    parameter int MEM_WORDS = 4096,
    localparam int AW = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [MEM_WORDS];

    assign rdata = mem_r[addr];

    // Word write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

endmodule

// File: rtl/dcache_line_mem.sv
// Line-granular memory responder: serialises 256-bit fills and writebacks into
// eight word accesses after a programmable latency.
module dcache_line_mem
    import dcache_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    dcache_line_mem_if.slave        bus,
    output logic                    busy
);

    localparam int AW            = $clog2(MEM_WORDS);
    localparam int LINE_IDX_BITS = 32 - OFFSET_BITS;
    localparam logic [15:0] LAT_LAST = 16'(LATENCY - 1);

    logic [1:0]               state_r;
    logic [1:0]               state_nxt_s;
    logic                     req_ready_r;
    logic                     resp_valid_r;
    logic                     busy_r;
    logic                     write_r;
    logic [LINE_IDX_BITS-1:0] line_r;
    logic [LINE_BITS-1:0]     wline_r;
    logic [LINE_BITS-1:0]     resp_line_r;
    logic [15:0]              lat_cnt_r;
    logic [BEAT_BITS-1:0]     beat_r;
    logic                     accept_s;
    logic                     we_s;
    logic [LINE_IDX_BITS+BEAT_BITS-1:0] waddr_full_s;
    logic [WORD_BITS-1:0]     wdata_s;
    logic [WORD_BITS-1:0]     rdata_s;
    logic                     unused_s;

    assign accept_s     = (state_r == ST_IDLE) && req_ready_r && bus.req_valid;
    assign waddr_full_s = {line_r, beat_r};
    // Gating with rst keeps a reset during BEAT from committing the pending word.
    assign we_s         = (state_r == ST_BEAT) && write_r && rst;
    assign wdata_s      = line_word(wline_r, beat_r);
    assign unused_s     = ^{bus.req_addr[OFFSET_BITS-1:0],
                            waddr_full_s[LINE_IDX_BITS+BEAT_BITS-1:AW]};

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_line  = resp_line_r;
    assign busy           = busy_r;

    dcache_word_ram #(.MEM_WORDS(MEM_WORDS)) u_ram (
        .clk   (clk),
        .we    (we_s),
        .addr  (waddr_full_s[AW-1:0]),
        .wdata (wdata_s),
        .rdata (rdata_s)
    );

    // Next-state selection for the request/latency/beat/response sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = (LATENCY > 0) ? ST_WAIT : ST_BEAT;
                else          state_nxt_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (lat_cnt_r == LAT_LAST) state_nxt_s = ST_BEAT;
                else                       state_nxt_s = ST_WAIT;
            end
            ST_BEAT: begin
                if (beat_r == 3'd7) state_nxt_s = ST_RESP;
                else                state_nxt_s = ST_BEAT;
            end
            ST_RESP: begin
                if (bus.resp_ready) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_RESP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, counters, registered handshake outputs and response line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            lat_cnt_r    <= 16'd0;
            beat_r       <= 3'd0;
            resp_line_r  <= '0;
        end else begin
            state_r      <= state_nxt_s;
            req_ready_r  <= (state_nxt_s == ST_IDLE);
            resp_valid_r <= (state_nxt_s == ST_RESP);
            busy_r       <= (state_nxt_s != ST_IDLE);
            if (state_r == ST_WAIT) lat_cnt_r <= lat_cnt_r + 16'd1;
            else                    lat_cnt_r <= 16'd0;
            if (state_r == ST_BEAT) begin
                beat_r      <= beat_r + 3'd1;
                resp_line_r <= line_put(resp_line_r, beat_r, write_r ? wdata_s : rdata_s);
            end else begin
                beat_r <= 3'd0;
            end
        end
    end

    // Request capture; fields stay frozen until the next acceptance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            write_r <= 1'b0;
            line_r  <= '0;
            wline_r <= '0;
        end else if (accept_s) begin
            write_r <= bus.req_write;
            line_r  <= bus.req_addr[31:OFFSET_BITS];
            wline_r <= bus.req_line;
        end
    end

endmodule
